// File: rtl/redun_mont_collect_pkg.sv
// Shared types and constants for the squaring-result collector.
// Provides the redundant/binary field-element types, the collector FSM state type
// and a digit-extraction helper for redundant values.
package redun_mont_collect_pkg;

    localparam int unsigned WRD_BITS   = 16;
    localparam int unsigned REDUN_BITS = 2;
    localparam int unsigned NUM_WRDS   = 8;
    localparam int unsigned DAT_BITS   = WRD_BITS * NUM_WRDS;
    localparam int unsigned T_LEN      = 8;

    localparam int unsigned DIG_BITS   = WRD_BITS + REDUN_BITS;
    // Ripple carry never exceeds 2^REDUN_BITS, so one extra bit is enough.
    localparam int unsigned CARRY_BITS = REDUN_BITS + 1;
    localparam int unsigned WRD_IDX_W  = $clog2(NUM_WRDS);

    typedef logic [DIG_BITS-1:0]   digit_t;
    typedef logic [WRD_BITS-1:0]   word_t;
    typedef logic [CARRY_BITS-1:0] carry_t;
    typedef digit_t [NUM_WRDS-1:0] redun0_t;
    typedef logic [DAT_BITS-1:0]   fe_t;

    typedef enum logic [1:0] {IDLE, COUNT, CONVERT, DONE} collect_state_t;

    // Digit i of a redundant value (weight 2^(WRD_BITS*i)).
    function automatic digit_t redun_digit(redun0_t v, int i);
        return v[i[WRD_IDX_W-1:0]];
    endfunction

endpackage

// File: rtl/redun_mont_collect_if.sv
// Handshake bundle between the host/squarer side and the collector.
//   i_start/i_t       : arm request and squaring count
//   i_mul/i_val       : redundant squarer result and its strobe
//   o_busy/o_err      : status, error pulse on a zero count
//   o_res/o_val/i_rdy : binary result with valid/ready handshake
interface redun_mont_collect_if;
    import redun_mont_collect_pkg::*;

    logic             i_start;
    logic [T_LEN-1:0] i_t;
    redun0_t          i_mul;
    logic             i_val;
    logic             o_busy;
    logic             o_err;
    fe_t              o_res;
    logic             o_val;
    logic             i_rdy;

    modport slave (
        input  i_start, i_t, i_mul, i_val, i_rdy,
        output o_busy, o_err, o_res, o_val
    );

    modport master (
        output i_start, i_t, i_mul, i_val, i_rdy,
        input  o_busy, o_err, o_res, o_val
    );

endinterface

// File: rtl/redun_carry_slice.sv
// Combinational carry ripple across Dpc redundant digits.
//   digits_i : Dpc redundant digits, least significant first
//   carry_i  : carry in from the previous slice
//   words_o  : Dpc resolved binary words
//   carry_o  : carry out of the most significant digit
module redun_carry_slice
    import redun_mont_collect_pkg::*;
#(
    parameter int unsigned Dpc = 4
) (
    input  digit_t [Dpc-1:0] digits_i,
    input  carry_t           carry_i,
    output word_t  [Dpc-1:0] words_o,
    output carry_t           carry_o
);

    typedef logic [DIG_BITS:0] acc_t;

    always_comb begin
        carry_t c;
        acc_t   acc;
        c       = carry_i;
        acc     = '0;
        words_o = '0;
        for (int j = 0; j < int'(Dpc); j++) begin
            acc        = acc_t'(digits_i[j]) + acc_t'(c);
            words_o[j] = acc[WRD_BITS-1:0];
            c          = acc[DIG_BITS:WRD_BITS];
        end
        carry_o = c;
    end

endmodule

// File: rtl/redun_mont_collect.sv
// Counts redundant squaring results, captures the i_t-th one, resolves it to binary
// DPC digits per cycle, and offers it on a valid/ready handshake.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : collector side of redun_mont_collect_if (see interface header)
module redun_mont_collect
    import redun_mont_collect_pkg::*;
#(
    parameter int unsigned DPC = 4
) (
    input logic                 i_clk,
    input logic                 i_rst,
    redun_mont_collect_if.slave bus
);

    localparam int unsigned NUM_CHUNKS = NUM_WRDS / DPC;
    localparam int unsigned CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);

    collect_state_t        state_q, state_d;
    logic [T_LEN-1:0]      tgt_q, tgt_d;
    logic [T_LEN-1:0]      cnt_q, cnt_d;
    logic [CHUNK_W-1:0]    chunk_q, chunk_d;
    carry_t                carry_q, carry_d;
    word_t [NUM_WRDS-1:0]  res_q, res_d;
    logic                  val_q, val_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    redun0_t               shadow_q;
    logic                  capture;

    digit_t [DPC-1:0]      slice_digits;
    word_t  [DPC-1:0]      slice_words;
    carry_t                slice_carry;

    // Present the DPC digits of the current chunk to the shared slice.
    always_comb begin
        slice_digits = '0;
        for (int c = 0; c < int'(NUM_CHUNKS); c++) begin
            if (chunk_q == CHUNK_W'(c)) begin
                for (int j = 0; j < int'(DPC); j++) begin
                    slice_digits[j] = redun_digit(shadow_q, c * int'(DPC) + j);
                end
            end
        end
    end

    redun_carry_slice #(
        .Dpc (DPC)
    ) u_slice (
        .digits_i (slice_digits),
        .carry_i  (carry_q),
        .words_o  (slice_words),
        .carry_o  (slice_carry)
    );

    always_comb begin
        int unsigned idx;
        idx     = 0;
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        chunk_d = chunk_q;
        carry_d = carry_q;
        res_d   = res_q;
        err_d   = 1'b0;
        capture = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    if (bus.i_t != '0) begin
                        tgt_d   = bus.i_t;
                        cnt_d   = '0;
                        state_d = COUNT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            COUNT: begin
                if (bus.i_val) begin
                    if (cnt_q == tgt_q - T_LEN'(1)) begin
                        capture = 1'b1;
                        chunk_d = '0;
                        carry_d = '0;
                        state_d = CONVERT;
                    end else begin
                        cnt_d = cnt_q + T_LEN'(1);
                    end
                end
            end
            CONVERT: begin
                for (int c = 0; c < int'(NUM_CHUNKS); c++) begin
                    if (chunk_q == CHUNK_W'(c)) begin
                        for (int j = 0; j < int'(DPC); j++) begin
                            idx = c * DPC + j;
                            res_d[idx[WRD_IDX_W-1:0]] = slice_words[j];
                        end
                    end
                end
                carry_d = slice_carry;
                chunk_d = chunk_q + CHUNK_W'(1);
                // Carry out of the top word is dropped: result is mod 2^DAT_BITS.
                if (chunk_q == LAST_CHUNK) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.i_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        val_d  = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            cnt_q   <= '0;
            chunk_q <= '0;
            carry_q <= '0;
            res_q   <= '0;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            chunk_q <= chunk_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            val_q   <= val_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Shadow is deliberately outside reset; it is only read after a fresh capture.
    always_ff @(posedge i_clk) begin
        if (capture) begin
            shadow_q <= bus.i_mul;
        end
    end

    assign bus.o_res  = res_q;
    assign bus.o_val  = val_q;
    assign bus.o_busy = busy_q;
    assign bus.o_err  = err_q;

endmodule

// File: tb/tb_redun_mont_collect.sv
// Directed/randomized bench for redun_mont_collect with a plain-arithmetic reference.
module tb_redun_mont_collect;
    import redun_mont_collect_pkg::*;

    localparam int unsigned DPC     = 4;
    localparam int unsigned LAT     = NUM_WRDS / DPC + 1;
    localparam int          DIG_MAX = (1 << DIG_BITS) - 1;
    typedef logic [DAT_BITS+DIG_BITS:0] wide_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    redun_mont_collect_if bus();

    redun_mont_collect #(
        .DPC (DPC)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Value of a redundant number, reduced mod 2^DAT_BITS.
    function automatic fe_t ref_value(redun0_t v);
        wide_t acc;
        acc = '0;
        for (int i = 0; i < int'(NUM_WRDS); i++) begin
            acc = acc + (wide_t'(v[i]) << (WRD_BITS * i));
        end
        return fe_t'(acc);
    endfunction

    function automatic redun0_t rand_redun();
        redun0_t r;
        for (int i = 0; i < int'(NUM_WRDS); i++) begin
            r[i] = digit_t'($urandom_range(0, DIG_MAX));
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input fe_t obs, input fe_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic arm(input logic [T_LEN-1:0] t);
        bus.i_start = 1'b1;
        bus.i_t     = t;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic strobe(input redun0_t v);
        bus.i_mul = v;
        bus.i_val = 1'b1;
        tick();
        bus.i_val = 1'b0;
    endtask

    // Cycles from now until o_val, bounded.
    task automatic wait_val(output int n);
        n = 0;
        while (bus.o_val !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic accept();
        bus.i_rdy = 1'b1;
        tick();
        bus.i_rdy = 1'b0;
        check_bit("val_after_accept", bus.o_val, 1'b0);
        check_bit("busy_after_accept", bus.o_busy, 1'b0);
    endtask

    // Arm with t, feed t strobes (random leading values), expect the last one resolved.
    task automatic run(input string tag, input logic [T_LEN-1:0] t, input redun0_t last_v,
                       input bit gaps);
        int n;
        arm(t);
        check_bit({tag, "_busy"}, bus.o_busy, 1'b1);
        for (int i = 1; i < int'(t); i++) begin
            strobe(rand_redun());
            if (gaps) repeat ($urandom_range(0, 2)) tick();
        end
        strobe(last_v);
        wait_val(n);
        // The capture cycle has already elapsed inside strobe().
        check_int({tag, "_latency"}, n, int'(LAT) - 1);
        check({tag, "_res"}, bus.o_res, ref_value(last_v));
        accept();
    endtask

    initial begin
        redun0_t v, a, b, c;
        int      n;
        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_t     = '0;
        bus.i_mul   = '0;
        bus.i_val   = 1'b0;
        bus.i_rdy   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_bit("rst_busy", bus.o_busy, 1'b0);
        check_bit("rst_err", bus.o_err, 1'b0);
        check_bit("rst_val", bus.o_val, 1'b0);
        check("rst_res", bus.o_res, '0);

        // Single squaring, value 2 in redundant form.
        v    = '0;
        v[0] = digit_t'(2);
        run("two", T_LEN'(1), v, 1'b0);

        // Every digit saturated: full carry chain, top carry discarded.
        v = '1;
        run("carry", T_LEN'(1), v, 1'b0);

        // Random counts and values, with idle gaps between strobes.
        for (int k = 0; k < 6; k++) begin
            run("rand", T_LEN'($urandom_range(1, 6)), rand_redun(), 1'b1);
        end

        // Largest legal count.
        run("tmax", '1, rand_redun(), 1'b0);

        // Backpressure while the squarer keeps strobing.
        v = rand_redun();
        arm(T_LEN'(1));
        strobe(v);
        wait_val(n);
        check_int("bp_latency", n, int'(LAT) - 1);
        for (int k = 0; k < 50; k++) begin
            bus.i_val = 1'($urandom_range(0, 1));
            bus.i_mul = rand_redun();
            tick();
            check_bit("bp_val", bus.o_val, 1'b1);
            check("bp_res", bus.o_res, ref_value(v));
        end
        bus.i_val = 1'b0;
        accept();

        // Zero count is an error pulse, no arming.
        bus.i_start = 1'b1;
        bus.i_t     = '0;
        tick();
        bus.i_start = 1'b0;
        check_bit("err_pulse", bus.o_err, 1'b1);
        check_bit("err_busy", bus.o_busy, 1'b0);
        tick();
        check_bit("err_clear", bus.o_err, 1'b0);

        // Start while busy is ignored; capture stays on the third strobe.
        a = rand_redun();
        b = rand_redun();
        c = rand_redun();
        arm(T_LEN'(3));
        strobe(a);
        bus.i_start = 1'b1;
        bus.i_t     = T_LEN'(5);
        bus.i_mul   = b;
        bus.i_val   = 1'b1;
        tick();
        bus.i_start = 1'b0;
        bus.i_val   = 1'b0;
        check_bit("busy_start_err", bus.o_err, 1'b0);
        strobe(c);
        wait_val(n);
        check_int("busy_start_latency", n, int'(LAT) - 1);
        check("busy_start_res", bus.o_res, ref_value(c));
        accept();

        // Reset in the middle of conversion, then re-arm.
        arm(T_LEN'(1));
        strobe(rand_redun());
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_bit("midrst_val", bus.o_val, 1'b0);
        check_bit("midrst_busy", bus.o_busy, 1'b0);
        check("midrst_res", bus.o_res, '0);
        run("rearm", T_LEN'(2), rand_redun(), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
